// File: rtl/tick_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tick_div_ctrl
//  Purpose  : Programmable tick / clock-divider controller. While enabled it
//             emits a one-cycle tick every N cycles and a divided square wave
//             of period N (high ceil(N/2), low floor(N/2)). The ratio N can be
//             reprogrammed through a valid/ready handshake; changes requested
//             while running are held in a shadow register and take effect at
//             the next period boundary so no period is ever truncated.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             en         - run enable
//             cfg_div    - requested divide ratio (WIDTH bits, must be >= 2)
//             cfg_valid  - cfg_div offered this cycle
//             cfg_ready  - controller can accept a configuration
//             cfg_err    - one-cycle pulse: offered ratio rejected
//             tick       - one-cycle pulse every N cycles
//             div_out    - divided square wave, period N
//             cur_div    - ratio currently in effect
//             busy       - a configuration is pending, not yet applied
//  Revision : 1.0 - initial release
// ============================================================================
module tick_div_ctrl #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             tick,
   output logic             div_out,
   output logic [WIDTH-1:0] cur_div,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] c_min_div     = WIDTH'(2);
   localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_zero        = '0;

   // Registered state
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_cur_div;
   logic [WIDTH-1:0] r_shadow;
   logic             r_tick;
   logic             r_div_out;
   logic             r_cfg_err;
   logic             r_busy;
   logic             r_cfg_ready;

   // Next-state values
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_cur_div_nxt;
   logic [WIDTH-1:0] w_shadow_nxt;
   logic             w_tick_nxt;
   logic             w_div_out_nxt;
   logic             w_cfg_err_nxt;
   logic             w_busy_nxt;
   logic             w_cfg_ready_nxt;

   // Handshake decode. cfg_ready is a register that always mirrors the
   // current state, so using it here is equivalent to decoding the state.
   logic             w_xfer;
   logic             w_bad;
   logic             w_good;
   logic             w_wrap;
   logic [WIDTH-1:0] w_cnt_inc;
   logic [WIDTH:0]   w_cur_ext;
   logic [WIDTH:0]   w_half;

   assign w_xfer    = cfg_valid & r_cfg_ready;
   assign w_bad     = (cfg_div < c_min_div);
   assign w_good    = w_xfer & ~w_bad;
   // cur_div is always >= 2 and cnt never exceeds cur_div-1, so neither the
   // subtraction nor the increment can wrap around, even at N = 2^WIDTH-1.
   assign w_wrap    = (r_cnt == (r_cur_div - c_one));
   assign w_cnt_inc = r_cnt + c_one;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= c_zero;
         r_cur_div   <= c_default_div;
         r_shadow    <= c_default_div;
         r_tick      <= 1'b0;
         r_div_out   <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_cfg_ready <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cur_div   <= w_cur_div_nxt;
         r_shadow    <= w_shadow_nxt;
         r_tick      <= w_tick_nxt;
         r_div_out   <= w_div_out_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
         r_busy      <= w_busy_nxt;
         r_cfg_ready <= w_cfg_ready_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cur_div_nxt = r_cur_div;
      w_shadow_nxt  = r_shadow;

      case (r_state)
         ST_IDLE: begin
            // Idle: ratio changes apply immediately; a simultaneous enable
            // starts the first period with the new ratio.
            w_cnt_nxt = c_zero;
            if (w_good) w_cur_div_nxt = cfg_div;
            if (en)     w_state_nxt   = ST_RUN;
         end

         ST_RUN: begin
            if (!en) begin
               // Leaving run: nothing can be pending here, but a request
               // accepted on this very edge is applied directly.
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = c_zero;
               if (w_good) w_cur_div_nxt = cfg_div;
            end else begin
               w_cnt_nxt = w_wrap ? c_zero : w_cnt_inc;
               // Even on a wrap edge the new ratio only lands in the shadow,
               // so the following period still runs with the old ratio.
               if (w_good) begin
                  w_shadow_nxt = cfg_div;
                  w_state_nxt  = ST_PEND;
               end
            end
         end

         ST_PEND: begin
            if (!en) begin
               w_state_nxt   = ST_IDLE;
               w_cnt_nxt     = c_zero;
               w_cur_div_nxt = r_shadow;
            end else if (w_wrap) begin
               w_state_nxt   = ST_RUN;
               w_cnt_nxt     = c_zero;
               w_cur_div_nxt = r_shadow;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = c_zero;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // -------------------------------------------------------------------------
   // Half-period threshold ceil(N/2), one bit wider so N = 2^WIDTH-1 fits.
   assign w_cur_ext = {1'b0, w_cur_div_nxt};
   assign w_half    = (w_cur_ext + (WIDTH+1)'(1)) >> 1;

   always_comb begin
      w_tick_nxt      = 1'b0;
      w_div_out_nxt   = 1'b0;
      w_cfg_err_nxt   = w_xfer & w_bad;
      w_busy_nxt      = (w_state_nxt == ST_PEND);
      w_cfg_ready_nxt = (w_state_nxt != ST_PEND);

      if (w_state_nxt != ST_IDLE) begin
         w_div_out_nxt = ({1'b0, w_cnt_nxt} < w_half);
         if (r_state != ST_IDLE) w_tick_nxt = w_wrap;
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign cfg_err   = r_cfg_err;
   assign tick      = r_tick;
   assign div_out   = r_div_out;
   assign cur_div   = r_cur_div;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tick_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_div_ctrl
//  Purpose  : Self-checking bench for tick_div_ctrl. A period-level reference
//             model (position within period, ratio in force, queue of pending
//             ratios) predicts every output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_div_ctrl;

   localparam int WIDTH       = 8;
   localparam int DEFAULT_DIV = 5;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_err;
   logic             tick;
   logic             div_out;
   logic [WIDTH-1:0] cur_div;
   logic             busy;

   tick_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_div   (cfg_div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .div_out   (div_out),
      .cur_div   (cur_div),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit m_run;
   int m_pos;
   int m_n;
   int m_pend[$];
   bit e_tick, e_div, e_err;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("tick",      int'(tick),      int'(e_tick));
      chk("div_out",   int'(div_out),   int'(e_div));
      chk("cfg_err",   int'(cfg_err),   int'(e_err));
      chk("cur_div",   int'(cur_div),   m_n);
      chk("busy",      int'(busy),      int'(m_pend.size() != 0));
      chk("cfg_ready", int'(cfg_ready), int'(m_pend.size() == 0));
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_pos  = 0;
      m_n    = DEFAULT_DIV;
      m_pend.delete();
      e_tick = 1'b0;
      e_div  = 1'b0;
      e_err  = 1'b0;
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_edge(input bit a_en, input bit a_valid, input int a_div);
      bit ready, xfer, good;
      ready  = (m_pend.size() == 0);
      xfer   = a_valid && ready;
      good   = xfer && (a_div >= 2);
      e_err  = xfer && !good;
      e_tick = 1'b0;
      if (!m_run) begin
         if (good) m_n = a_div;
         if (a_en) begin
            m_run = 1'b1;
            m_pos = 0;
         end
      end else if (!a_en) begin
         if (m_pend.size() != 0) m_n = m_pend.pop_front();
         else if (good)          m_n = a_div;
         m_run = 1'b0;
         m_pos = 0;
      end else begin
         if (m_pos == m_n - 1) begin
            m_pos  = 0;
            e_tick = 1'b1;
            if (m_pend.size() != 0) m_n = m_pend.pop_front();
         end else begin
            m_pos++;
         end
         // Accepted after the period boundary is resolved: takes effect next time.
         if (good) m_pend.push_back(a_div);
      end
      e_div = m_run && (m_pos < (m_n + 1) / 2);
   endtask

   // Drive inputs, clock one edge, then check all outputs 1 time unit later.
   task automatic step(input bit a_en, input bit a_valid, input int a_div);
      en        = a_en;
      cfg_valid = a_valid;
      cfg_div   = WIDTH'(a_div);
      model_edge(a_en, a_valid, a_div);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // Default ratio, free running
      run_cycles(16);

      // Rejected ratios while running
      step(1'b1, 1'b1, 1);
      run_cycles(2);
      step(1'b1, 1'b1, 0);
      run_cycles(6);

      // Reprogram to 8 mid-period, then observe several periods
      step(1'b1, 1'b1, 8);
      step(1'b1, 1'b1, 3);   // offered while pending: must be ignored
      run_cycles(24);

      // Pending 3 then drop enable, re-enable
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      run_cycles(10);

      // Offer on the exact wrap edge
      for (int i = 0; i < 10 && !(m_run && m_pos == m_n - 1); i++) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 6);
      run_cycles(20);

      // Extreme ratios: N = 2 then N = 2^WIDTH-1
      step(1'b0, 1'b1, 2);
      run_cycles(8);
      step(1'b0, 1'b1, (1 << WIDTH) - 1);
      run_cycles(2 * ((1 << WIDTH) - 1) + 4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int  r, d;
         bit  v, e;
         r = int'($urandom_range(0, 11));
         case (r)
            0:       d = 0;
            1:       d = 1;
            2:       d = 2;
            3:       d = (1 << WIDTH) - 1;
            4:       d = int'($urandom_range(13, (1 << WIDTH) - 1));
            default: d = int'($urandom_range(3, 12));
         endcase
         v = ($urandom_range(0, 5) == 0);
         e = ($urandom_range(0, 39) != 0);
         step(e, v, d);
      end

      // Asynchronous reset between edges while a configuration is pending
      step(1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 200);
      step(1'b1, 1'b0, 0);
      chk("busy_before_rst", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      step(1'b0, 1'b0, 0);
      run_cycles(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got 0 expected 1 (simulation time limit)");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
